// File: rtl/result_drain_pkg.sv
// Shared defaults and FSM state encoding for the result-memory drain engine.
package result_drain_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ROWS   = 5;
  localparam int DEF_COLS   = 5;
  localparam int DEF_ADDR_W = 5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_HOLD    = 3'd3;
  localparam state_t ST_FINISH  = 3'd4;
endpackage

// File: rtl/result_drain_relu.sv
// Combinational ReLU: negative two's-complement values clamp to zero when enabled.
// Only compiled when RESULT_DRAIN_RELU_EN is defined.
`ifdef RESULT_DRAIN_RELU_EN
module drain_relu
  import result_drain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_en,
  output logic [DATA_W-1:0] o_data
);
  assign o_data = (i_en && i_data[DATA_W-1]) ? '0 : i_data;
endmodule
`endif

// File: rtl/result_drain.sv
// Drains a ROWS x COLS result memory as a valid/ready stream, one element per 3 cycles.
// Optional ReLU on the drained data when built with RESULT_DRAIN_RELU_EN.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              relu_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_row,
  output logic [2:0]        out_col,
  output logic              out_last,
  output logic              busy,
  output logic              drain_done
);
  localparam logic [ADDR_W-1:0] LP_IDX_LAST = ADDR_W'(ROWS * COLS - 1);
  localparam logic [2:0]        LP_COL_LAST = 3'(COLS - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_index;
  logic [2:0]        r_row;
  logic [2:0]        r_col;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_capture_data;
  logic              w_last;

  assign w_last = (r_index == LP_IDX_LAST);

`ifdef RESULT_DRAIN_RELU_EN
  logic r_relu;

  // ReLU mode is frozen for the whole drain at the accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_relu <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_relu <= relu_en;
    end
  end

  drain_relu #(
    .DATA_W (DATA_W)
  ) u_relu (
    .i_data (rd_data),
    .i_en   (r_relu),
    .o_data (w_capture_data)
  );
`else
  logic w_unused_relu_en;
  assign w_unused_relu_en = relu_en;
  assign w_capture_data   = rd_data;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_next = ST_FETCH;
      ST_FETCH:   w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_HOLD;
      ST_HOLD:    if (out_ready) w_state_next = w_last ? ST_FINISH : ST_FETCH;
      ST_FINISH:  w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_index <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_index <= '0;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        ST_CAPTURE: r_data <= w_capture_data;
        ST_HOLD: begin
          // Counters only advance on a non-final handshake, so they saturate at the last element.
          if (out_ready && !w_last) begin
            r_index <= r_index + 1'b1;
            if (r_col == LP_COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en      = (r_state == ST_FETCH);
  assign rd_addr    = (r_state == ST_FETCH) ? r_index : '0;
  assign out_data   = r_data;
  assign out_valid  = (r_state == ST_HOLD);
  assign out_row    = r_row;
  assign out_col    = r_col;
  assign out_last   = (r_state == ST_HOLD) && w_last;
  assign busy       = (r_state != ST_IDLE);
  assign drain_done = (r_state == ST_FINISH);
endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: plain, ReLU, back-pressure, ignored restart and mid-drain reset.
module tb_result_drain;
`ifdef RESULT_DRAIN_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        relu_en;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_row;
  logic [2:0]  out_col;
  logic        out_last;
  logic        busy;
  logic        drain_done;

  logic [15:0] mem [0:31];
  int          n_checks;
  int          n_errors;

  result_drain dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .relu_en    (relu_en),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .drain_done (drain_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result memory model: registered read, data one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_val(input int k, input logic relu);
    logic [15:0] v;
    v = 16'(k - 12);
    if (RELU_ON && relu && k < 12) v = '0;
    return v;
  endfunction

  task automatic check_zero(input string tag);
    chk(tag, {rd_en, rd_addr, out_data, out_valid, out_row, out_col, out_last, busy, drain_done}, 32'd0);
  endtask

  task automatic do_drain(input logic relu, input int stall_at, input int start_at, input int abort_at);
    int hs = 0;
    int rdp = 0;
    int dones = 0;
    int cyc = 0;
    int stall_left = 10;
    int first_valid = -1;
    int last_hs = -1;
    int post = 0;
    bit restarted = 1'b0;
    start     = 1'b1;
    relu_en   = relu;
    out_ready = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    relu_en = 1'b0;
    while (cyc < 300 && post < 4) begin
      start = 1'b0;
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), 32'(rdp));
        rdp++;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (abort_at >= 0 && out_valid && hs == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_zero("async_reset_zero");
        return;
      end
      if (out_valid && hs == start_at && !restarted) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      if (out_valid) begin
        chk("out_data", 32'(out_data), 32'(exp_val(hs, relu)));
        chk("out_row", 32'(out_row), 32'(hs / 5));
        chk("out_col", 32'(out_col), 32'(hs % 5));
        chk("out_last", 32'(out_last), 32'(hs == 24));
        if (hs == stall_at && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
        if (out_ready) begin
          $display("elem %0d row %0d col %0d data %0d last %0d", hs, out_row, out_col,
                   $signed(out_data), out_last);
          last_hs = cyc;
          hs++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (drain_done) begin
        dones++;
        chk("done_after_last", 32'(cyc), 32'(last_hs + 1));
      end
      if (dones > 0) post++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("handshakes", 32'(hs), 32'd25);
    chk("drain_done_count", 32'(dones), 32'd1);
    chk("rd_pulses", 32'(rdp), 32'd25);
    chk("first_valid_cyc", 32'(first_valid), 32'd2);
    chk("last_hs_cyc", 32'(last_hs), 32'(stall_at >= 0 ? 84 : 74));
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    relu_en   = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) mem[k] = 16'(k - 12);
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_zero("idle_after_release");

    do_drain(1'b0, -1, -1, -1);
    do_drain(1'b1, -1, -1, -1);
    do_drain(1'b0, 7, -1, -1);
    do_drain(1'b0, -1, 3, -1);
    do_drain(1'b0, -1, -1, 10);
    repeat (2) @(negedge clk);
    check_zero("held_in_reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("idle_after_abort");
    do_drain(1'b0, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
